// File: rtl/axilite_timer_if.sv
// AXI4-Lite bus bundle between the core's data master and the machine timer.
interface axilite_timer_if;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, arready, rvalid, rdata
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, arready, rvalid, rdata
    );
endinterface

// File: rtl/axilite_timer.sv
// RISC-V machine timer (mtime/mtimecmp/prescaler/irq) behind an AXI4-Lite slave.
// AW, W and AR are accepted independently; one write response outstanding at a time.
module axilite_timer #(
    parameter int ADDR_BITS = 5,
    parameter int PRESC_W   = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    axilite_timer_if.slave  axi,
    output logic            timer_irq_o
);
    localparam int IDX_W = ADDR_BITS - 2;

    localparam logic [IDX_W-1:0] A_MTIME_LO = IDX_W'(0);
    localparam logic [IDX_W-1:0] A_MTIME_HI = IDX_W'(1);
    localparam logic [IDX_W-1:0] A_CMP_LO   = IDX_W'(2);
    localparam logic [IDX_W-1:0] A_CMP_HI   = IDX_W'(3);
    localparam logic [IDX_W-1:0] A_PRESC    = IDX_W'(4);
    localparam logic [IDX_W-1:0] A_CTRL     = IDX_W'(5);

    // Byte-strobe merge of a 32-bit register image
    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        return res;
    endfunction

    logic               r_live;
    logic               r_aw_held;
    logic               r_w_held;
    logic [IDX_W-1:0]   r_waddr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_wstrb;
    logic               r_bvalid;
    logic               r_rvalid;
    logic [31:0]        r_rdata;
    logic [63:0]        r_mtime;
    logic [63:0]        r_mtimecmp;
    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] r_presc_cnt;
    logic               r_en;
    logic [31:0]        r_hi_shadow;
    logic               r_irq;

    logic               w_awready;
    logic               w_wready;
    logic               w_arready;
    logic               w_aw_hs;
    logic               w_w_hs;
    logic               w_ar_hs;
    logic               w_wr_fire;
    logic [IDX_W-1:0]   w_rd_idx;
    logic [31:0]        w_rd_data;
    logic               w_tick;
    logic [31:0]        w_presc_merged;
    logic               w_unused;

    // Readies stay low through reset and the first cycle after it
    assign w_awready = r_live && !r_aw_held && !r_bvalid;
    assign w_wready  = r_live && !r_w_held  && !r_bvalid;
    assign w_arready = r_live && !r_rvalid;

    assign w_aw_hs   = axi.awvalid && w_awready;
    assign w_w_hs    = axi.wvalid  && w_wready;
    assign w_ar_hs   = axi.arvalid && w_arready;
    assign w_wr_fire = r_aw_held && r_w_held && !r_bvalid;
    assign w_rd_idx  = axi.araddr[ADDR_BITS-1:2];
    assign w_tick    = r_en && (r_presc_cnt == r_presc);

    assign w_presc_merged = f_merge({{(32-PRESC_W){1'b0}}, r_presc}, r_wdata, r_wstrb);

    assign w_unused = ^{axi.awprot, axi.arprot, axi.awaddr[31:ADDR_BITS], axi.awaddr[1:0],
                        axi.araddr[31:ADDR_BITS], axi.araddr[1:0], w_presc_merged[31:PRESC_W]};

    assign axi.awready = w_awready;
    assign axi.wready  = w_wready;
    assign axi.arready = w_arready;
    assign axi.bvalid  = r_bvalid;
    assign axi.rvalid  = r_rvalid;
    assign axi.rdata   = r_rdata;
    assign timer_irq_o = r_irq;

    // Bus-enable flag: low in reset, high from the first clock after release
    always_ff @(posedge clk) begin
        if (!rst_n) r_live <= 1'b0;
        else        r_live <= 1'b1;
    end

    // Write channel: latch AW and W independently, commit and respond once both are held
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_waddr   <= axi.awaddr[ADDR_BITS-1:2];
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= axi.wdata;
                r_wstrb  <= axi.wstrb;
            end
            if (w_wr_fire)
                r_bvalid <= 1'b1;
            if (r_bvalid && axi.bready) begin
                r_bvalid  <= 1'b0;
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
            end
        end
    end

    // Read mux over the current (pre-write) register values
    always_comb begin
        w_rd_data = 32'h0;
        case (w_rd_idx)
            A_MTIME_LO: w_rd_data = r_mtime[31:0];
            A_MTIME_HI: w_rd_data = r_hi_shadow;
            A_CMP_LO:   w_rd_data = r_mtimecmp[31:0];
            A_CMP_HI:   w_rd_data = r_mtimecmp[63:32];
            A_PRESC:    w_rd_data = {{(32-PRESC_W){1'b0}}, r_presc};
            A_CTRL:     w_rd_data = {31'h0, r_en};
            default:    w_rd_data = 32'h0;
        endcase
    end

    // Read channel: register data on AR handshake, hold until rready
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rvalid    <= 1'b0;
            r_rdata     <= '0;
            r_hi_shadow <= '0;
        end else begin
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
                if (w_rd_idx == A_MTIME_LO)
                    r_hi_shadow <= r_mtime[63:32];
            end else if (r_rvalid && axi.rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // mtime and prescaler; a bus write to mtime suppresses that cycle's increment
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mtime     <= '0;
            r_presc_cnt <= '0;
        end else begin
            if (w_wr_fire && r_waddr == A_MTIME_LO)
                r_mtime <= {r_mtime[63:32], f_merge(r_mtime[31:0], r_wdata, r_wstrb)};
            else if (w_wr_fire && r_waddr == A_MTIME_HI)
                r_mtime <= {f_merge(r_mtime[63:32], r_wdata, r_wstrb), r_mtime[31:0]};
            else if (w_tick)
                r_mtime <= r_mtime + 64'd1;

            if (w_wr_fire && (r_waddr == A_PRESC || r_waddr == A_CTRL))
                r_presc_cnt <= '0;
            else if (r_en)
                r_presc_cnt <= w_tick ? '0 : r_presc_cnt + 1'b1;
        end
    end

    // Configuration registers: mtimecmp, prescaler, enable
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mtimecmp <= '1;
            r_presc    <= '0;
            r_en       <= 1'b0;
        end else if (w_wr_fire) begin
            case (r_waddr)
                A_CMP_LO: r_mtimecmp[31:0]  <= f_merge(r_mtimecmp[31:0], r_wdata, r_wstrb);
                A_CMP_HI: r_mtimecmp[63:32] <= f_merge(r_mtimecmp[63:32], r_wdata, r_wstrb);
                A_PRESC:  r_presc           <= w_presc_merged[PRESC_W-1:0];
                A_CTRL:   if (r_wstrb[0]) r_en <= r_wdata[0];
                default:  ;
            endcase
        end
    end

    // Level interrupt, registered compare of current mtime against mtimecmp
    always_ff @(posedge clk) begin
        if (!rst_n) r_irq <= 1'b0;
        else        r_irq <= (r_mtime >= r_mtimecmp);
    end
endmodule

// File: tb/tb_axilite_timer.sv
// Directed bench for axilite_timer: bus handshakes, register map, counter, irq, reset.
module tb_axilite_timer;
    logic clk;
    logic rst_n;
    logic irq;
    int   n_chk;
    int   n_fail;

    axilite_timer_if bus ();

    axilite_timer #(.ADDR_BITS(5), .PRESC_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .axi         (bus.slave),
        .timer_irq_o (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int   n;
        logic a, w;
        bus.awvalid = 1'b1; bus.awaddr = addr;
        bus.wvalid  = 1'b1; bus.wdata  = data; bus.wstrb = strb;
        n = 0;
        while ((bus.awvalid || bus.wvalid) && n < 20) begin
            a = bus.awready;
            w = bus.wready;
            tick();
            n++;
            if (a) bus.awvalid = 1'b0;
            if (w) bus.wvalid  = 1'b0;
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        n = 0;
        while (!bus.bvalid && n < 20) begin
            tick();
            n++;
        end
        chk("wr_bvalid", bus.bvalid, 1);
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
        int   n;
        logic a;
        bus.arvalid = 1'b1; bus.araddr = addr;
        n = 0;
        while (bus.arvalid && n < 20) begin
            a = bus.arready;
            tick();
            n++;
            if (a) bus.arvalid = 1'b0;
        end
        bus.arvalid = 1'b0;
        n = 0;
        while (!bus.rvalid && n < 20) begin
            tick();
            n++;
        end
        chk("rd_rvalid", bus.rvalid, 1);
        data = bus.rdata;
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, d2;
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0;
        bus.awvalid = 0; bus.awaddr = 0; bus.awprot = 0;
        bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.bready = 0;
        bus.arvalid = 0; bus.araddr = 0; bus.arprot = 0; bus.rready = 0;

        // 1. reset values
        repeat (3) tick();
        chk("rst_awready", bus.awready, 0);
        chk("rst_wready",  bus.wready,  0);
        chk("rst_arready", bus.arready, 0);
        chk("rst_bvalid",  bus.bvalid,  0);
        chk("rst_rvalid",  bus.rvalid,  0);
        chk("rst_rdata",   bus.rdata,   0);
        chk("rst_irq",     irq,         0);
        rst_n = 1'b1;
        repeat (2) tick();
        axi_read(32'h08, d); chk("rst_cmp_lo", d, 32'hFFFF_FFFF);
        axi_read(32'h0C, d); chk("rst_cmp_hi", d, 32'hFFFF_FFFF);
        axi_read(32'h00, d); chk("rst_mtime_lo", d, 0);

        // 2. W three cycles ahead of AW to CTRL
        bus.wvalid = 1'b1; bus.wdata = 32'h0000_0005; bus.wstrb = 4'hF;
        tick();
        bus.wvalid = 1'b0;
        tick(); tick();
        chk("w_only_no_b", bus.bvalid, 0);
        bus.awvalid = 1'b1; bus.awaddr = 32'h14;
        tick();
        bus.awvalid = 1'b0;
        chk("aw_lat_no_b", bus.bvalid, 0);
        tick();
        chk("aw_w_bvalid", bus.bvalid, 1);
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        chk("b_cleared", bus.bvalid, 0);
        tick();
        chk("b_once", bus.bvalid, 0);
        axi_read(32'h14, d); chk("ctrl_en", d, 1);
        axi_read(32'h00, d);
        axi_read(32'h00, d2);
        chk("mtime_counts", d2 - d, 2);

        // 3. prescaler 3 -> one increment per 4 cycles
        axi_write(32'h14, 0, 4'hF);
        axi_write(32'h00, 0, 4'hF);
        axi_write(32'h04, 0, 4'hF);
        axi_write(32'h10, 3, 4'hF);
        axi_read(32'h10, d); chk("presc_rd", d, 3);
        axi_write(32'h14, 1, 4'hF);
        repeat (40) tick();
        axi_read(32'h00, d);
        chk("presc_rate", (d >= 9 && d <= 11), 1);

        // 4. carry from low into high word
        axi_write(32'h14, 0, 4'hF);
        axi_write(32'h04, 0, 4'hF);
        axi_write(32'h00, 32'hFFFF_FFFE, 4'hF);
        axi_write(32'h10, 0, 4'hF);
        axi_write(32'h14, 1, 4'hF);
        tick();
        axi_read(32'h00, d); chk("carry_lo", d, 0);
        axi_read(32'h04, d); chk("carry_hi_shadow", d, 1);

        // bus write to mtime wins over the increment; high half untouched
        axi_write(32'h00, 32'd100, 4'hF);
        axi_read(32'h00, d); chk("wr_wins_lo", d, 101);
        axi_read(32'h04, d); chk("wr_keeps_hi", d, 1);

        // 5. interrupt timing
        axi_write(32'h14, 0, 4'hF);
        axi_write(32'h0C, 0, 4'hF);
        axi_write(32'h08, 32'd20, 4'hF);
        axi_write(32'h00, 0, 4'hF);
        axi_write(32'h04, 0, 4'hF);
        axi_write(32'h14, 1, 4'hF);
        chk("irq_low_start", irq, 0);
        repeat (19) tick();
        chk("irq_before", irq, 0);
        tick();
        chk("irq_rise", irq, 1);
        axi_write(32'h0C, 1, 4'hF);
        chk("irq_fall", irq, 0);

        // strobes, unmapped offsets, aliasing, register widths
        axi_write(32'h14, 0, 4'hF);
        axi_write(32'h08, 32'hAABB_CCDD, 4'b0010);
        axi_read(32'h08, d); chk("strb_byte1", d, 32'h0000_CC14);
        axi_write(32'h0C, 32'h1234_5678, 4'b0000);
        axi_read(32'h0C, d); chk("strb_zero", d, 1);
        axi_write(32'h18, 32'hFFFF_FFFF, 4'hF);
        axi_read(32'h18, d); chk("unmapped_rd", d, 0);
        axi_read(32'h28, d); chk("alias_cmp_lo", d, 32'h0000_CC14);
        axi_write(32'h10, 32'hFFFF_FFFF, 4'hF);
        axi_read(32'h10, d); chk("presc_width", d, 32'hFF);
        axi_read(32'h14, d); chk("ctrl_off", d, 0);

        // 6. rready stall keeps the read response stable
        bus.arvalid = 1'b1; bus.araddr = 32'h08;
        tick();
        bus.arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_rvalid",  bus.rvalid,  1);
            chk("stall_rdata",   bus.rdata,   32'h0000_CC14);
            chk("stall_arready", bus.arready, 0);
            tick();
        end
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        chk("stall_released", bus.rvalid, 0);

        // reset while AW is held without W: captured address is dropped
        bus.awvalid = 1'b1; bus.awaddr = 32'h10;
        tick();
        bus.awvalid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        bus.wvalid = 1'b1; bus.wdata = 32'h7; bus.wstrb = 4'hF;
        tick();
        bus.wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("rst_drop_no_b", bus.bvalid, 0);
            tick();
        end
        axi_read(32'h10, d); chk("rst_drop_presc", d, 0);
        axi_read(32'h0C, d); chk("rst_again_cmp_hi", d, 32'hFFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
